m3_commutation_sequencer: RTL and testbench

//  Slice timer + 6-step commutation sequencer for the 3-phase motor path.

---
 rtl/m3_commutation_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_m3_commutation_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m3_commutation_sequencer.sv
// Slice timer and 6-step commutation sequencer for the 3-phase motor path.
// Each slice lasts dst_round_len clocks, clamped up to PERIOD_MIN. Every slice
// opens with a DEAD_CYC all-off window and then drives the table pattern for
// the current step. next_round_1 paces the speed calculator once per 6 slices.
// Ports:
//   clk, rst              clock, async active-high reset
//   working               run enable
//   m3_inv_rotate         1 = reverse step order (sampled on round wrap)
//   m3_force_stop         brake request, overrides working
//   dst_round_len         requested slice period in clocks
//   next_round_1          1-clk pulse when the slice index wraps 5->0
//   next_slice_1          1-clk pulse at every slice boundary
//   step                  current commutation step 0..5
//   phase_high/phase_low  switch enables {C,B,A}
//   cur_slice_period      period in use for the current slice
//   running               1 while in RUN
module m3_commutation_sequencer #(
  parameter int unsigned SLICE_NUM  = 6,
  parameter int unsigned PERIOD_MIN = 40,
  parameter int unsigned DEAD_CYC   = 4,
  parameter int unsigned BRAKE_CYC  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        working,
  input  logic        m3_inv_rotate,
  input  logic        m3_force_stop,
  input  logic [31:0] dst_round_len,
  output logic        next_round_1,
  output logic        next_slice_1,
  output logic [2:0]  step,
  output logic [2:0]  phase_high,
  output logic [2:0]  phase_low,
  output logic [31:0] cur_slice_period,
  output logic        running
);

  localparam logic [31:0] PeriodMin = 32'(PERIOD_MIN);
  localparam logic [31:0] DeadCyc   = 32'(DEAD_CYC);
  localparam logic [31:0] BrakeLast = 32'(BRAKE_CYC - 1);
  localparam logic [2:0]  LastStep  = 3'(SLICE_NUM - 1);

  typedef enum logic [1:0] {StIdle, StRun, StBrake} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] period_q, period_d;
  logic [31:0] brake_q, brake_d;
  logic [2:0]  step_q, step_d;
  logic [2:0]  slice_q, slice_d;
  logic        dir_q, dir_d;
  logic        next_slice_q, next_slice_d;
  logic        next_round_q, next_round_d;
  logic        running_q, running_d;
  logic [2:0]  high_q, high_d;
  logic [2:0]  low_q, low_d;
  logic [31:0] period_clamped;

  assign period_clamped = (dst_round_len < PeriodMin) ? PeriodMin : dst_round_len;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    brake_d      = brake_q;
    step_d       = step_q;
    slice_d      = slice_q;
    dir_d        = dir_q;
    next_slice_d = 1'b0;
    next_round_d = 1'b0;

    if (m3_force_stop) begin
      // Holding the request keeps restarting the brake window.
      state_d = StBrake;
      brake_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (working) begin
            state_d  = StRun;
            cnt_d    = '0;
            period_d = period_clamped;
            step_d   = '0;
            slice_d  = '0;
            dir_d    = m3_inv_rotate;
          end
        end
        StRun: begin
          if (!working) begin
            state_d = StIdle;
          end else if (cnt_q == period_q - 32'd1) begin
            cnt_d        = '0;
            period_d     = period_clamped;
            next_slice_d = 1'b1;
            next_round_d = (slice_q == LastStep);
            slice_d      = (slice_q == LastStep) ? 3'd0 : slice_q + 3'd1;
            if (dir_q) begin
              step_d = (step_q == 3'd0) ? LastStep : step_q - 3'd1;
            end else begin
              step_d = (step_q == LastStep) ? 3'd0 : step_q + 3'd1;
            end
            // Direction only changes at a round boundary, after this step move.
            if (slice_q == LastStep) begin
              dir_d = m3_inv_rotate;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        StBrake: begin
          if (brake_q >= BrakeLast) begin
            state_d = StIdle;
          end else begin
            brake_d = brake_q + 32'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    running_d = (state_d == StRun);

    // Switch pattern follows the registered state/step/cnt it is stored with.
    high_d = 3'b000;
    low_d  = 3'b000;
    if (state_d == StBrake) begin
      low_d = 3'b111;
    end else if (state_d == StRun && cnt_d >= DeadCyc) begin
      unique case (step_d)
        3'd0: begin high_d = 3'b001; low_d = 3'b010; end
        3'd1: begin high_d = 3'b001; low_d = 3'b100; end
        3'd2: begin high_d = 3'b010; low_d = 3'b100; end
        3'd3: begin high_d = 3'b010; low_d = 3'b001; end
        3'd4: begin high_d = 3'b100; low_d = 3'b001; end
        3'd5: begin high_d = 3'b100; low_d = 3'b010; end
        default: begin high_d = 3'b000; low_d = 3'b000; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      period_q     <= PeriodMin;
      brake_q      <= '0;
      step_q       <= '0;
      slice_q      <= '0;
      dir_q        <= 1'b0;
      next_slice_q <= 1'b0;
      next_round_q <= 1'b0;
      running_q    <= 1'b0;
      high_q       <= '0;
      low_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      brake_q      <= brake_d;
      step_q       <= step_d;
      slice_q      <= slice_d;
      dir_q        <= dir_d;
      next_slice_q <= next_slice_d;
      next_round_q <= next_round_d;
      running_q    <= running_d;
      high_q       <= high_d;
      low_q        <= low_d;
    end
  end

  assign next_slice_1     = next_slice_q;
  assign next_round_1     = next_round_q;
  assign running          = running_q;
  assign step             = step_q;
  assign cur_slice_period = period_q;
  assign phase_high       = high_q;
  assign phase_low        = low_q;

  // No shoot-through on any leg.
  a_no_shoot_through: assert property (@(posedge clk) disable iff (rst)
    (high_q & low_q) == 3'b000);

  // A drive pattern may only follow another drive pattern if it is the same one.
  a_dead_window: assert property (@(posedge clk) disable iff (rst)
    (high_q != 3'b000 && $past(high_q) != 3'b000) |-> (high_q == $past(high_q)));

endmodule

// File: tb/tb_m3_commutation_sequencer.sv
module tb_m3_commutation_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        working = 1'b0;
  logic        m3_inv_rotate = 1'b0;
  logic        m3_force_stop = 1'b0;
  logic [31:0] dst_round_len = 32'd40;
  logic        next_round_1, next_slice_1, running;
  logic [2:0]  step, phase_high, phase_low;
  logic [31:0] cur_slice_period;

  int checks = 0;
  int failures = 0;

  m3_commutation_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .working          (working),
    .m3_inv_rotate    (m3_inv_rotate),
    .m3_force_stop    (m3_force_stop),
    .dst_round_len    (dst_round_len),
    .next_round_1     (next_round_1),
    .next_slice_1     (next_slice_1),
    .step             (step),
    .phase_high       (phase_high),
    .phase_low        (phase_low),
    .cur_slice_period (cur_slice_period),
    .running          (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time-based view: a slice started at edge s ends at edge s+len; a brake
  // requested at edge b is released at edge b+1000 if not re-requested.
  int          m_mode;  // 0 idle, 1 run, 2 brake
  longint      cyc = 0;
  longint      slice_start = 0;
  longint      stop_edge = 0;
  longint      m_len;
  int          m_slice, m_step;
  bit          m_inv;
  logic        e_ns, e_nr, e_run;
  logic [2:0]  e_hi, e_lo, e_step;
  logic [31:0] e_per;
  // Phase index (A=0,B=1,C=2) driven high / low for each step.
  int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
  int lo_ph[6] = '{1, 2, 2, 0, 0, 1};

  function automatic longint clamp(input logic [31:0] v);
    return (v < 32'd40) ? 64'd40 : longint'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_slice = 0; m_step = 0; m_inv = 0; m_len = 40;
      e_ns = 0; e_nr = 0; e_run = 0; e_hi = 0; e_lo = 0; e_step = 0; e_per = 40;
    end else begin
      cyc++;
      e_ns = 0;
      e_nr = 0;
      if (m3_force_stop) begin
        m_mode = 2;
        stop_edge = cyc;
      end else if (m_mode == 0) begin
        if (working) begin
          m_mode = 1; slice_start = cyc; m_len = clamp(dst_round_len);
          m_slice = 0; m_step = 0; m_inv = m3_inv_rotate;
        end
      end else if (m_mode == 1) begin
        if (!working) begin
          m_mode = 0;
        end else if (cyc - slice_start == m_len) begin
          slice_start = cyc;
          e_ns = 1;
          m_slice = (m_slice + 1) % 6;
          e_nr = (m_slice == 0);
          m_step = (m_step + (m_inv ? 5 : 1)) % 6;
          if (m_slice == 0) m_inv = m3_inv_rotate;
          m_len = clamp(dst_round_len);
        end
      end else if (cyc - stop_edge >= 1000) begin
        m_mode = 0;
      end
      e_run  = (m_mode == 1);
      e_step = 3'(m_step);
      e_per  = m_len[31:0];
      e_hi   = 3'b000;
      e_lo   = 3'b000;
      if (m_mode == 2) begin
        e_lo = 3'b111;
      end else if (m_mode == 1 && cyc - slice_start >= 4) begin
        e_hi = 3'(1 << hi_ph[m_step]);
        e_lo = 3'(1 << lo_ph[m_step]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({next_slice_1, next_round_1, running, step, phase_high, phase_low, cur_slice_period}
          !== {e_ns, e_nr, e_run, e_step, e_hi, e_lo, e_per}) begin
        failures++;
        $display("FAIL model_compare t=%0t got ns=%b nr=%b run=%b step=%0d hi=%b lo=%b per=%0d expected ns=%b nr=%b run=%b step=%0d hi=%b lo=%b per=%0d",
                 $time, next_slice_1, next_round_1, running, step, phase_high, phase_low,
                 cur_slice_period, e_ns, e_nr, e_run, e_step, e_hi, e_lo, e_per);
      end
    end
  end

  // Counts negedges until a next_slice pulse is seen; 500 means it never came.
  task automatic wait_slice(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!next_slice_1 && n < 500);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int np;
    int t5_step[7] = '{3, 4, 5, 0, 5, 4, 3};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_period", 64'(cur_slice_period), 64'd40);
    check("reset_running", 64'(running), 64'd0);
    check("reset_switches", 64'({phase_high, phase_low}), 64'd0);

    // T2: forward run at the minimum period.
    working = 1'b1;
    @(negedge clk);
    check("t2_running", 64'(running), 64'd1);
    check("t2_step0", 64'(step), 64'd0);
    repeat (3) @(negedge clk);
    check("t2_dead_cnt3", 64'({phase_high, phase_low}), 64'd0);
    @(negedge clk);
    check("t2_a_plus_b_minus", 64'({phase_high, phase_low}), 64'({3'b001, 3'b010}));
    wait_slice(n);
    check("t2_first_gap", 64'(n), 64'd36);
    check("t2_step_1", 64'(step), 64'd1);
    for (int k = 2; k <= 6; k++) begin
      wait_slice(n);
      check("t2_gap", 64'(n), 64'd40);
      check("t2_step", 64'(step), 64'(k % 6));
      check("t2_round", 64'(next_round_1), 64'(k == 6));
    end

    // T3: period change mid-slice takes effect on the next slice.
    repeat (10) @(negedge clk);
    dst_round_len = 32'd100;
    wait_slice(n);
    check("t3_old_slice_end", 64'(n), 64'd30);
    check("t3_period_update", 64'(cur_slice_period), 64'd100);
    wait_slice(n);
    check("t3_long_slice", 64'(n), 64'd100);

    // T4: clamping of short requests.
    dst_round_len = 32'd10;
    wait_slice(n);
    check("t4_gap_before_clamp", 64'(n), 64'd100);
    check("t4_clamp10", 64'(cur_slice_period), 64'd40);
    dst_round_len = 32'd0;
    wait_slice(n);
    check("t4_gap_clamped", 64'(n), 64'd40);
    check("t4_clamp0", 64'(cur_slice_period), 64'd40);
    repeat (4) wait_slice(n);
    check("t5_start_step", 64'(step), 64'd2);

    // T5: reverse request at slice 2 waits for the round wrap.
    m3_inv_rotate = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_slice(n);
      check("t5_step", 64'(step), 64'(t5_step[k]));
      check("t5_round", 64'(next_round_1), 64'(k == 3));
    end

    // T6: force stop at cnt=20 of step 3.
    repeat (20) @(negedge clk);
    m3_force_stop = 1'b1;
    @(negedge clk);
    m3_force_stop = 1'b0;
    working = 1'b0;
    check("t6_brake_pattern", 64'({phase_high, phase_low}), 64'({3'b000, 3'b111}));
    check("t6_not_running", 64'(running), 64'd0);
    n = 0;
    while (phase_low == 3'b111 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("t6_brake_len", 64'(n), 64'd1000);
    check("t6_idle_off", 64'({phase_high, phase_low, running}), 64'd0);
    working = 1'b1;
    @(negedge clk);
    check("t6_restart_run", 64'(running), 64'd1);
    check("t6_restart_step", 64'(step), 64'd0);
    wait_slice(n);
    check("t6_restart_gap", 64'(n), 64'd40);
    check("t6_reverse_step", 64'(step), 64'd5);

    // working falls exactly at a slice boundary: no pulse, back to idle.
    repeat (39) @(negedge clk);
    working = 1'b0;
    @(negedge clk);
    check("fall_no_pulse", 64'({next_slice_1, next_round_1}), 64'd0);
    check("fall_idle", 64'(running), 64'd0);

    // T1: async reset in the middle of a run.
    working = 1'b1;
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t1_async_outputs", 64'({next_slice_1, next_round_1, running, step, phase_high, phase_low}), 64'd0);
    check("t1_async_period", 64'(cur_slice_period), 64'd40);
    working = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    repeat (60) begin
      @(negedge clk);
      if (next_slice_1 || next_round_1 || running) np++;
    end
    check("t1_no_glitch", 64'(np), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop well beyond the expected run length.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
